// File: rtl/ext_bus_pkg.sv
// ---------------------------------------------------------------------------
// ext_bus_pkg
// Shared definitions for the external memory bus arbiter:
//   - bus_state_e   : transaction sequencer states
//   - MEMIO_*       : encodings of the MemIO request field
//   - DRV_*         : bit positions inside ExternalDrive
//   - memio_pending : true when MemIO carries a real read/write request
// ---------------------------------------------------------------------------
package ext_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } bus_state_e;

    localparam logic [1:0] MEMIO_IDLE  = 2'b00;
    localparam logic [1:0] MEMIO_READ  = 2'b01;
    localparam logic [1:0] MEMIO_WRITE = 2'b10;
    localparam logic [1:0] MEMIO_RSVD  = 2'b11;

    localparam int DRV_ADDR = 0;
    localparam int DRV_DATA = 1;
    localparam int DRV_RD   = 2;

    // The reserved code behaves exactly like idle.
    function automatic logic memio_pending(input logic [1:0] code);
        case (code)
            MEMIO_READ, MEMIO_WRITE: return 1'b1;
            MEMIO_IDLE, MEMIO_RSVD:  return 1'b0;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ext_bus_arbiter_grant_arb.sv
// ---------------------------------------------------------------------------
// bus_grant_arb
// Chooses between the fetch and data requesters while the sequencer is idle.
// Data normally wins; after MAX_DATA_BURST data grants taken while a fetch
// was waiting, the fetch is forced through.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   arb_en_i          : sequencer is idle and may accept a grant this edge
//   fetch_req_i       : fetch request
//   mem_io_i          : data request code (MemIO)
//   grant_fetch_o     : fetch wins this edge (combinational)
//   grant_data_o      : data wins this edge (combinational)
// ---------------------------------------------------------------------------
module bus_grant_arb
    import ext_bus_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en_i,
    input  logic       fetch_req_i,
    input  logic [1:0] mem_io_i,
    output logic       grant_fetch_o,
    output logic       grant_data_o
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    logic [3:0] starve_q, starve_d;
    logic       data_req;

    assign data_req = memio_pending(mem_io_i);

    always_comb begin
        grant_fetch_o = 1'b0;
        grant_data_o  = 1'b0;
        starve_d      = starve_q;
        if (arb_en_i) begin
            if (data_req && fetch_req_i) begin
                if (starve_q == BURST_MAX) begin
                    grant_fetch_o = 1'b1;
                end else begin
                    grant_data_o = 1'b1;
                end
            end else if (data_req) begin
                grant_data_o = 1'b1;
            end else if (fetch_req_i) begin
                grant_fetch_o = 1'b1;
            end

            // Only data grants that overtake a waiting fetch count as starvation.
            if (!fetch_req_i || grant_fetch_o) begin
                starve_d = '0;
            end else if (grant_data_o && (starve_q != BURST_MAX)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/ext_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ext_bus_arbiter
// Sequences the single external memory bus between instruction fetch and
// data load/store. Each grant runs ADDR -> WAIT -> DONE (or ERR on timeout).
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   FetchReq, PCAddressBus  : fetch request and address
//   MemIO, ALUAddressBus,
//   InternalDataBus         : data request code, address, store data
//   ExternalDataIn,
//   ExternalExchangeReady   : external read data and transfer-complete
//   ExternalAddressBus,
//   ExternalDataOut,
//   ExternalDrive           : registered bus address, store data, drive bits
//   InstructionBus,
//   NewInstruction          : last fetched word, fetch-complete pulse
//   MemReadData,
//   ValidMemoryData         : last loaded word, data-complete pulse
//   BusError                : timeout pulse
//   Busy                    : sequencer not idle
// ---------------------------------------------------------------------------
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        FetchReq,
    input  logic [31:0] PCAddressBus,
    input  logic [1:0]  MemIO,
    input  logic [31:0] ALUAddressBus,
    input  logic [31:0] InternalDataBus,
    input  logic [31:0] ExternalDataIn,
    input  logic        ExternalExchangeReady,
    output logic [31:0] ExternalAddressBus,
    output logic [31:0] ExternalDataOut,
    output logic [2:0]  ExternalDrive,
    output logic [31:0] InstructionBus,
    output logic        NewInstruction,
    output logic [31:0] MemReadData,
    output logic        ValidMemoryData,
    output logic        BusError,
    output logic        Busy
);

    // Counter value on the last WAIT edge before giving up.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    bus_state_e  state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        fetch_own_q, fetch_own_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  drive_q, drive_d;
    logic        new_instr_q, new_instr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        arb_en;
    logic        grant_fetch, grant_data, grant_wr;

    assign arb_en   = (state_q == ST_IDLE);
    assign grant_wr = grant_data && (MemIO == MEMIO_WRITE);

    bus_grant_arb #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .arb_en_i     (arb_en),
        .fetch_req_i  (FetchReq),
        .mem_io_i     (MemIO),
        .grant_fetch_o(grant_fetch),
        .grant_data_o (grant_data)
    );

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        fetch_own_d = fetch_own_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        drive_d     = drive_q;
        new_instr_d = 1'b0;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_fetch || grant_data) begin
                    fetch_own_d       = grant_fetch;
                    wr_d              = grant_wr;
                    addr_d            = grant_fetch ? PCAddressBus : ALUAddressBus;
                    dout_d            = grant_wr ? InternalDataBus : dout_q;
                    drive_d           = '0;
                    drive_d[DRV_ADDR] = 1'b1;
                    drive_d[DRV_DATA] = grant_wr;
                    drive_d[DRV_RD]   = ~grant_wr;
                    state_d           = ST_ADDR;
                end
            end
            ST_ADDR: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (ExternalExchangeReady) begin
                    state_d = ST_DONE;
                    drive_d = '0;
                    if (fetch_own_q) begin
                        new_instr_d = 1'b1;
                        instr_d     = ExternalDataIn;
                    end else begin
                        valid_d = 1'b1;
                        if (!wr_q) begin
                            rdata_d = ExternalDataIn;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERR;
                    drive_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                drive_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            fetch_own_q <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            instr_q     <= '0;
            rdata_q     <= '0;
            drive_q     <= '0;
            new_instr_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            fetch_own_q <= fetch_own_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
            drive_q     <= drive_d;
            new_instr_q <= new_instr_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign ExternalAddressBus = addr_q;
    assign ExternalDataOut    = dout_q;
    assign ExternalDrive      = drive_q;
    assign InstructionBus     = instr_q;
    assign NewInstruction     = new_instr_q;
    assign MemReadData        = rdata_q;
    assign ValidMemoryData    = valid_q;
    assign BusError           = err_q;
    assign Busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ext_bus_arbiter
// Self-checking bench for ext_bus_arbiter (MAX_DATA_BURST=4, TIMEOUT_CYCLES=8):
// a table of cycle vectors, hand sequences for arbitration fairness, timeout,
// address latching and asynchronous reset, then randomized traffic compared
// against a transaction-timeline reference model.
// ---------------------------------------------------------------------------
module tb_ext_bus_arbiter;

    localparam int MAXB = 4;
    localparam int TMO  = 8;

    logic        clk;
    logic        rst;
    logic        FetchReq;
    logic [31:0] PCAddressBus;
    logic [1:0]  MemIO;
    logic [31:0] ALUAddressBus;
    logic [31:0] InternalDataBus;
    logic [31:0] ExternalDataIn;
    logic        ExternalExchangeReady;
    logic [31:0] ExternalAddressBus;
    logic [31:0] ExternalDataOut;
    logic [2:0]  ExternalDrive;
    logic [31:0] InstructionBus;
    logic        NewInstruction;
    logic [31:0] MemReadData;
    logic        ValidMemoryData;
    logic        BusError;
    logic        Busy;

    int n_tests = 0;
    int n_fail  = 0;

    ext_bus_arbiter #(
        .MAX_DATA_BURST(MAXB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .FetchReq             (FetchReq),
        .PCAddressBus         (PCAddressBus),
        .MemIO                (MemIO),
        .ALUAddressBus        (ALUAddressBus),
        .InternalDataBus      (InternalDataBus),
        .ExternalDataIn       (ExternalDataIn),
        .ExternalExchangeReady(ExternalExchangeReady),
        .ExternalAddressBus   (ExternalAddressBus),
        .ExternalDataOut      (ExternalDataOut),
        .ExternalDrive        (ExternalDrive),
        .InstructionBus       (InstructionBus),
        .NewInstruction       (NewInstruction),
        .MemReadData          (MemReadData),
        .ValidMemoryData      (ValidMemoryData),
        .BusError             (BusError),
        .Busy                 (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fetch;
        logic [31:0] pc;
        logic [1:0]  memio;
        logic [31:0] alu;
        logic [31:0] wdat;
        logic [31:0] din;
        logic        rdy;
        logic [2:0]  e_drv;
        logic [31:0] e_addr;
        logic [31:0] e_dout;
        logic        e_newi;
        logic [31:0] e_instr;
        logic        e_vmd;
        logic [31:0] e_mrd;
        logic        e_berr;
        logic        e_busy;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] drv, input logic [31:0] addr,
                           input logic [31:0] dout, input logic newi, input logic [31:0] instr,
                           input logic vmd, input logic [31:0] mrd, input logic berr,
                           input logic busy);
        chk({tag, ".drive"}, 32'(ExternalDrive), 32'(drv));
        chk({tag, ".addr"},  ExternalAddressBus, addr);
        chk({tag, ".dout"},  ExternalDataOut, dout);
        chk({tag, ".newi"},  32'(NewInstruction), 32'(newi));
        chk({tag, ".instr"}, InstructionBus, instr);
        chk({tag, ".vmd"},   32'(ValidMemoryData), 32'(vmd));
        chk({tag, ".mrd"},   MemReadData, mrd);
        chk({tag, ".berr"},  32'(BusError), 32'(berr));
        chk({tag, ".busy"},  32'(Busy), 32'(busy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    int          m_n;       // edge number since reset
    int          m_g;       // edge at which the current access was granted
    int          m_fin;     // edge at which the last access completed/aborted
    bit          m_act;     // an access is in flight
    bit          m_own_f;
    bit          m_wr;
    int          m_starve;
    logic [2:0]  m_drv;
    logic [31:0] m_addr, m_dout, m_instr, m_mrd;
    logic        m_newi, m_vmd, m_berr, m_busy;

    function automatic void model_reset();
        m_n = 0; m_g = 0; m_fin = -10; m_act = 0; m_own_f = 0; m_wr = 0; m_starve = 0;
        m_drv = '0; m_addr = '0; m_dout = '0; m_instr = '0; m_mrd = '0;
        m_newi = 0; m_vmd = 0; m_berr = 0; m_busy = 0;
    endfunction

    // Called right after an edge; the bench inputs still hold their pre-edge values.
    function automatic void model_step();
        bit dpend, take_f, take_d;
        m_n++;
        m_newi = 0; m_vmd = 0; m_berr = 0;
        if (m_act) begin
            // The access waits for ready on edges g+2 .. g+1+TMO.
            if (m_n >= m_g + 2) begin
                if (ExternalExchangeReady) begin
                    m_act = 0; m_fin = m_n; m_drv = 3'b000;
                    if (m_own_f) begin
                        m_newi = 1; m_instr = ExternalDataIn;
                    end else begin
                        m_vmd = 1;
                        if (!m_wr) m_mrd = ExternalDataIn;
                    end
                end else if (m_n - (m_g + 1) == TMO) begin
                    m_act = 0; m_fin = m_n; m_drv = 3'b000; m_berr = 1;
                end
            end
        end else if (m_n >= m_fin + 2) begin
            dpend  = (MemIO == 2'b01) || (MemIO == 2'b10);
            take_f = (dpend && FetchReq) ? (m_starve == MAXB) : FetchReq;
            take_d = dpend && !take_f;
            if (!FetchReq || take_f) m_starve = 0;
            else if (take_d && m_starve < MAXB) m_starve = m_starve + 1;
            if (take_f || take_d) begin
                m_act   = 1;
                m_g     = m_n;
                m_own_f = take_f;
                m_wr    = take_d && (MemIO == 2'b10);
                m_addr  = take_f ? PCAddressBus : ALUAddressBus;
                if (m_wr) m_dout = InternalDataBus;
                m_drv   = m_wr ? 3'b011 : 3'b101;
            end
        end
        m_busy = m_act || (m_n == m_fin);
    endfunction

    logic [31:0] exp_order[10];
    logic [2:0]  prev_drv;
    int          ng;
    int          r;

    initial begin
        // ---------------- vector table: fetch, write, read ----------------
        //          fetch pc      memio  alu     wdat          din           rdy   drv     addr    dout          newi instr   vmd mrd           berr busy
        vecs[0]  = '{1'b1, 32'h100, 2'b00, 32'h0,  32'h0,        32'h0,        1'b0, 3'b101, 32'h100, 32'h0,        1'b0, 32'd0,    1'b0, 32'h0,        1'b0, 1'b1};
        vecs[1]  = '{1'b1, 32'h100, 2'b00, 32'h0,  32'h0,        32'd1281,     1'b1, 3'b101, 32'h100, 32'h0,        1'b0, 32'd0,    1'b0, 32'h0,        1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h100, 2'b00, 32'h0,  32'h0,        32'd1281,     1'b1, 3'b000, 32'h100, 32'h0,        1'b1, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'h100, 2'b00, 32'h0,  32'h0,        32'h0,        1'b0, 3'b000, 32'h100, 32'h0,        1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,   2'b10, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 3'b011, 32'h20,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,   2'b10, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 3'b011, 32'h20,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,   2'b10, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 3'b011, 32'h20,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,   2'b10, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 3'b011, 32'h20,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,   2'b10, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 3'b011, 32'h20,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,   2'b10, 32'h20, 32'hDEADBEEF, 32'h12345678, 1'b1, 3'b000, 32'h20,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b1, 32'h0,        1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0,   2'b00, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 3'b000, 32'h20,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0,   2'b01, 32'h44, 32'h0,        32'h0,        1'b0, 3'b101, 32'h44,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h0,   2'b01, 32'h44, 32'h0,        32'hCAFEF00D, 1'b1, 3'b101, 32'h44,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'h0,   2'b01, 32'h44, 32'h0,        32'hCAFEF00D, 1'b1, 3'b000, 32'h44,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 32'h0,   2'b00, 32'h0,  32'h0,        32'h0,        1'b0, 3'b000, 32'h44,  32'hDEADBEEF, 1'b0, 32'd1281, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};

        rst = 1'b0; FetchReq = 1'b0; PCAddressBus = '0; MemIO = 2'b00; ALUAddressBus = '0;
        InternalDataBus = '0; ExternalDataIn = '0; ExternalExchangeReady = 1'b0;
        repeat (2) step();
        chk_all("reset", 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #4 rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            FetchReq = vecs[i].fetch; PCAddressBus = vecs[i].pc; MemIO = vecs[i].memio;
            ALUAddressBus = vecs[i].alu; InternalDataBus = vecs[i].wdat;
            ExternalDataIn = vecs[i].din; ExternalExchangeReady = vecs[i].rdy;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_drv, vecs[i].e_addr, vecs[i].e_dout,
                    vecs[i].e_newi, vecs[i].e_instr, vecs[i].e_vmd, vecs[i].e_mrd,
                    vecs[i].e_berr, vecs[i].e_busy);
        end

        // ---------------- starvation limit: D,D,D,D,F repeating ----------------
        for (int i = 0; i < 10; i++) exp_order[i] = (i % 5 == 4) ? 32'h1000 : 32'h2000;
        FetchReq = 1'b1; PCAddressBus = 32'h1000; MemIO = 2'b01; ALUAddressBus = 32'h2000;
        ExternalExchangeReady = 1'b1; ExternalDataIn = 32'hF0F00000;
        prev_drv = 3'b000; ng = 0;
        for (int c = 0; c < 200 && ng < 10; c++) begin
            step();
            if (ExternalDrive != 3'b000 && prev_drv == 3'b000) begin
                chk($sformatf("grant_order%0d", ng), ExternalAddressBus, exp_order[ng]);
                ng++;
            end
            prev_drv = ExternalDrive;
        end
        chk("grant_count", 32'(ng), 32'd10);
        FetchReq = 1'b0; MemIO = 2'b00;
        repeat (3) step();
        chk("burst.busy",  32'(Busy), 32'd0);
        chk("burst.instr", InstructionBus, 32'hF0F00000);
        chk("burst.mrd",   MemReadData, 32'hF0F00000);

        // ---------------- timeout, then retry ----------------
        FetchReq = 1'b1; PCAddressBus = 32'h300; ExternalExchangeReady = 1'b0; ExternalDataIn = 32'hBAD;
        step();
        chk("tmo.addr_phase", 32'(ExternalDrive), 32'(3'b101));
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("tmo.noerr%0d", i), 32'(BusError), 32'd0);
            chk($sformatf("tmo.nopulse%0d", i), 32'(NewInstruction), 32'd0);
        end
        step();
        chk_all("tmo.err", 3'b000, 32'h300, 32'hDEADBEEF, 1'b0, 32'hF0F00000, 1'b0, 32'hF0F00000, 1'b1, 1'b1);
        step();
        chk("tmo.idle_berr", 32'(BusError), 32'd0);
        chk("tmo.idle_busy", 32'(Busy), 32'd0);
        step();
        chk("retry.drive", 32'(ExternalDrive), 32'(3'b101));
        chk("retry.addr",  ExternalAddressBus, 32'h300);
        ExternalExchangeReady = 1'b1; ExternalDataIn = 32'h444;
        step();
        step();
        chk("retry.newi",  32'(NewInstruction), 32'd1);
        chk("retry.instr", InstructionBus, 32'h444);
        FetchReq = 1'b0; ExternalExchangeReady = 1'b0;
        step();

        // ---------------- address latched against later input changes ----------------
        FetchReq = 1'b1; PCAddressBus = 32'h100;
        step();
        chk("latch.addr0", ExternalAddressBus, 32'h100);
        PCAddressBus = 32'h200;
        step();
        chk("latch.addr1", ExternalAddressBus, 32'h100);
        step();
        chk("latch.addr2", ExternalAddressBus, 32'h100);
        ExternalExchangeReady = 1'b1; ExternalDataIn = 32'h777;
        step();
        chk("latch.newi",  32'(NewInstruction), 32'd1);
        chk("latch.addr3", ExternalAddressBus, 32'h100);
        FetchReq = 1'b0; ExternalExchangeReady = 1'b0;
        step();

        // ---------------- asynchronous reset during WAIT ----------------
        FetchReq = 1'b1; PCAddressBus = 32'h500;
        repeat (3) step();
        chk("arst.pre_drive", 32'(ExternalDrive), 32'(3'b101));
        #2 rst = 1'b0;
        #1;
        chk_all("arst", 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        step();
        chk("arst.restart_drive", 32'(ExternalDrive), 32'(3'b101));
        chk("arst.restart_addr",  ExternalAddressBus, 32'h500);
        ExternalExchangeReady = 1'b1; ExternalDataIn = 32'h555;
        step();
        step();
        chk("arst.newi",  32'(NewInstruction), 32'd1);
        chk("arst.instr", InstructionBus, 32'h555);
        FetchReq = 1'b0; ExternalExchangeReady = 1'b0;
        step();

        // ---------------- randomized traffic against the model ----------------
        rst = 1'b0; MemIO = 2'b00;
        #2 rst = 1'b1;
        model_reset();
        for (int c = 0; c < 2500; c++) begin
            if (m_newi) FetchReq = 1'b0;
            else if (!FetchReq && $urandom_range(0, 2) == 0) FetchReq = 1'b1;
            if (m_vmd) begin
                MemIO = 2'b00;
            end else if (!(MemIO == 2'b01 || MemIO == 2'b10)) begin
                r = int'($urandom_range(0, 5));
                MemIO = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            end
            PCAddressBus = $urandom; ALUAddressBus = $urandom; InternalDataBus = $urandom;
            ExternalDataIn = $urandom;
            ExternalExchangeReady = ($urandom_range(0, 3) == 0);
            step();
            model_step();
            chk_all("rnd", m_drv, m_addr, m_dout, m_newi, m_instr, m_vmd, m_mrd, m_berr, m_busy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
